// File: rtl/sram_to_sram_write_multi_if.sv
// ---------------------------------------------------------------------------
// sram_to_sram_write_multi_if
// Purpose : bundles the upstream valid/ready data stream and the shared
//           destination-SRAM write port of the multi-channel write-back stage.
// Signals : s_data  [CHANNELS][DATA_BITS]  lane data from the compute stage
//           s_valid                         upstream word valid
//           s_ready                         write-back stage can accept a word
//           m_wen   [CHANNELS]              per-channel SRAM write enable
//           m_waddr [ADDR_BITS]             shared SRAM write address
//           m_wdata [CHANNELS][DATA_BITS]   per-channel SRAM write data
// Modports: slave  - the write-back stage (consumes stream, drives SRAMs)
//           master - the environment (drives stream, observes SRAM port)
// ---------------------------------------------------------------------------
interface sram_to_sram_write_multi_if #(
   parameter int CHANNELS  = 2,
   parameter int ADDR_BITS = 10,
   parameter int DATA_BITS = 64
);
   logic [CHANNELS-1:0][DATA_BITS-1:0] s_data;
   logic                               s_valid;
   logic                               s_ready;
   logic [CHANNELS-1:0]                m_wen;
   logic [ADDR_BITS-1:0]               m_waddr;
   logic [CHANNELS-1:0][DATA_BITS-1:0] m_wdata;

   modport slave (
      input  s_data, s_valid,
      output s_ready, m_wen, m_waddr, m_wdata
   );

   modport master (
      output s_data, s_valid,
      input  s_ready, m_wen, m_waddr, m_wdata
   );
endinterface

// File: rtl/sram_to_sram_write_multi.sv
// ---------------------------------------------------------------------------
// sram_to_sram_write_multi
// Purpose : write-back stage of the SRAM-to-SRAM pipeline. Accepts words from
//           the compute stage over valid/ready and writes each lane to its own
//           destination SRAM at a shared, auto-incrementing address. Supports a
//           programmable base/length, per-run channel mask, abort, and a
//           one-shot or continuous (wrap) mode.
// Ports   : i_clk        clock, rising edge
//           i_reset      asynchronous active-high reset
//           i_cke        clock enable; 0 freezes every register
//           i_start      start pulse, sampled in IDLE
//           i_abort      abandon the current run
//           i_cfg_base   first write address (latched at start)
//           i_cfg_len    words per run, 0 = 2**ADDR_BITS (latched at start)
//           i_cfg_wrap   1 = continuous mode (latched at start)
//           i_cfg_mask   per-channel write enable (latched at start)
//           o_busy       state != IDLE
//           o_done       one-cycle pulse after the last write of a one-shot run
//           o_wcount     words written in the current/last run (saturating)
//           bus          stream input + SRAM write port (slave modport)
// ---------------------------------------------------------------------------
module sram_to_sram_write_multi #(
   parameter int CHANNELS  = 2,
   parameter int ADDR_BITS = 10,
   parameter int DATA_BITS = 64
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_cke,
   input  logic                 i_start,
   input  logic                 i_abort,
   input  logic [ADDR_BITS-1:0] i_cfg_base,
   input  logic [ADDR_BITS-1:0] i_cfg_len,
   input  logic                 i_cfg_wrap,
   input  logic [CHANNELS-1:0]  i_cfg_mask,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [ADDR_BITS:0]   o_wcount,
   sram_to_sram_write_multi_if.slave bus
);
   typedef logic [ADDR_BITS-1:0] addr_t;
   typedef logic [ADDR_BITS:0]   cnt_t;
   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   localparam addr_t ONE_A = addr_t'(1);
   localparam cnt_t  ONE_C = cnt_t'(1);

   state_t                             r_state;
   addr_t                              r_base;
   addr_t                              r_len;
   addr_t                              r_addr;
   addr_t                              r_waddr;
   logic                               r_wrap;
   logic [CHANNELS-1:0]                r_mask;
   logic                               r_ready;
   logic                               r_done;
   logic                               r_done_pend;
   cnt_t                               r_beat;
   cnt_t                               r_wcount;
   logic [CHANNELS-1:0]                r_wen_st;
   logic [CHANNELS-1:0][DATA_BITS-1:0] r_wdata;

   logic w_s_ready;
   logic w_accept;
   cnt_t w_len_eff;
   logic w_last;

   // abort must block a beat presented in the same cycle, so it masks the
   // registered ready combinationally.
   assign w_s_ready = r_ready & ~i_abort;
   assign w_accept  = bus.s_valid & w_s_ready & i_cke;
   // A programmed length of zero stands for the full address space.
   assign w_len_eff = (r_len == '0) ? {1'b1, {ADDR_BITS{1'b0}}} : {1'b0, r_len};
   assign w_last    = ((r_beat + ONE_C) == w_len_eff);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_base      <= '0;
         r_len       <= '0;
         r_addr      <= '0;
         r_waddr     <= '0;
         r_wrap      <= 1'b0;
         r_mask      <= '0;
         r_ready     <= 1'b0;
         r_done      <= 1'b0;
         r_done_pend <= 1'b0;
         r_beat      <= '0;
         r_wcount    <= '0;
         r_wen_st    <= '0;
      end else if (i_cke) begin
         // Write strobes and done are single-cycle unless re-armed below.
         r_wen_st    <= '0;
         r_done      <= r_done_pend;
         r_done_pend <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_base   <= i_cfg_base;
                  r_len    <= i_cfg_len;
                  r_wrap   <= i_cfg_wrap;
                  r_mask   <= i_cfg_mask;
                  r_addr   <= i_cfg_base;
                  r_beat   <= '0;
                  r_wcount <= '0;
                  r_ready  <= 1'b1;
                  r_state  <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (i_abort) begin
                  r_ready <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (w_accept) begin
                  r_wen_st <= r_mask;
                  r_waddr  <= r_addr;
                  if (!r_wcount[ADDR_BITS]) begin
                     r_wcount <= r_wcount + ONE_C;
                  end
                  if (w_last && r_wrap) begin
                     r_addr <= r_base;
                     r_beat <= '0;
                  end else if (w_last) begin
                     // done is delayed one more cycle so it follows the last m_wen.
                     r_addr      <= r_addr + ONE_A;
                     r_ready     <= 1'b0;
                     r_done_pend <= 1'b1;
                     r_state     <= ST_IDLE;
                  end else begin
                     r_addr <= r_addr + ONE_A;
                     r_beat <= r_beat + ONE_C;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Write data is a pure datapath register: its reset value is irrelevant.
   always_ff @(posedge i_clk) begin
      if (w_accept) begin
         r_wdata <= bus.s_data;
      end
   end

   // Strobes are gated by cke so a write held across a stall lands only once.
   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
         assign bus.m_wen[gi]   = r_wen_st[gi] & i_cke;
         assign bus.m_wdata[gi] = r_wdata[gi];
      end
   endgenerate

   assign bus.s_ready = w_s_ready;
   assign bus.m_waddr = r_waddr;
   assign o_busy      = (r_state == ST_RUN);
   assign o_done      = r_done;
   assign o_wcount    = r_wcount;
endmodule
